// File: rtl/cpu_rp2a03_apu_frame_sequencer_pkg.sv
// RP2A03 APU frame sequencer shared constants:
// NTSC step compare points, mode encoding and $4017 write delays.
package cpu_rp2a03_apu_pkg;

  localparam int unsigned FS_CNT_W = 16;
  localparam int unsigned FS_STEP1 = 7456;
  localparam int unsigned FS_STEP2 = 14912;
  localparam int unsigned FS_STEP3 = 22370;
  localparam int unsigned FS_STEP4 = 29828;
  localparam int unsigned FS_STEP5 = 37280;

  typedef enum logic {
    FS_MODE_4STEP = 1'b0,
    FS_MODE_5STEP = 1'b1
  } fs_mode_e;

  localparam logic [2:0] FS_DLY_EVEN = 3'd3;
  localparam logic [2:0] FS_DLY_ODD  = 3'd4;

endpackage

// File: rtl/cpu_rp2a03_apu_frame_sequencer_write_delay.sv
// $4017 write delay: CPU-cycle phase, delay counter and pending flag.
// reset_seq_o pulses on the CPU cycle where the delay runs out.
module cpu_rp2a03_apu_frame_write_delay
  import cpu_rp2a03_apu_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpu_cycle_en_i,
  input  logic frame_counter_reg_wr_i,
  output logic reset_seq_o
);

  logic       phase;
  logic       pend;
  logic [2:0] dly;

  // a write in the expiring cycle restarts the delay instead
  assign reset_seq_o = cpu_cycle_en_i
                     & pend
                     & ~frame_counter_reg_wr_i
                     & (dly == 3'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase <= 1'b0;
      pend  <= 1'b0;
      dly   <= '0;
    end else begin
      if (cpu_cycle_en_i) begin
        phase <= ~phase;
      end
      if (frame_counter_reg_wr_i) begin
        pend <= 1'b1;
        dly  <= phase ? FS_DLY_ODD : FS_DLY_EVEN;
      end else if (cpu_cycle_en_i && pend) begin
        dly  <= dly - 3'd1;
        pend <= (dly != 3'd1);
      end
    end
  end

endmodule

// File: rtl/cpu_rp2a03_apu_frame_sequencer.sv
// RP2A03 APU frame sequencer ($4017): quarter/half-frame strobes, frame IRQ.
// Frame IRQ logic is built only when APU_FRAME_IRQ_EN is defined.
module cpu_rp2a03_apu_frame_sequencer
  import cpu_rp2a03_apu_pkg::*;
#(
  parameter int unsigned CNT_W_P = FS_CNT_W,
  parameter int unsigned STEP1_P = FS_STEP1,
  parameter int unsigned STEP2_P = FS_STEP2,
  parameter int unsigned STEP3_P = FS_STEP3,
  parameter int unsigned STEP4_P = FS_STEP4,
  parameter int unsigned STEP5_P = FS_STEP5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpu_cycle_en_i,
  input  logic       frame_counter_reg_wr_i,
  input  logic [7:0] data_i,
  input  logic       status_reg_rd_i,
  output logic       mode_o,
  output logic       quarter_frame_o,
  output logic       half_frame_o,
  output logic       frame_irq_o
);

  localparam logic [CNT_W_P-1:0] S1 = CNT_W_P'(STEP1_P);
  localparam logic [CNT_W_P-1:0] S2 = CNT_W_P'(STEP2_P);
  localparam logic [CNT_W_P-1:0] S3 = CNT_W_P'(STEP3_P);
  localparam logic [CNT_W_P-1:0] S4 = CNT_W_P'(STEP4_P);
  localparam logic [CNT_W_P-1:0] S5 = CNT_W_P'(STEP5_P);
  localparam logic [CNT_W_P-1:0] W4 = CNT_W_P'(STEP4_P + 1);
  localparam logic [CNT_W_P-1:0] W5 = CNT_W_P'(STEP5_P + 1);
  localparam logic [CNT_W_P-1:0] ONE = CNT_W_P'(1);

  fs_mode_e           mode;
  logic [CNT_W_P-1:0] cnt;
  logic [CNT_W_P-1:0] last;
  logic [CNT_W_P-1:0] wrap;
  logic               reset_seq;
  logic               q_hit;
  logic               h_hit;

  cpu_rp2a03_apu_frame_write_delay u_write_delay (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .cpu_cycle_en_i         (cpu_cycle_en_i),
    .frame_counter_reg_wr_i (frame_counter_reg_wr_i),
    .reset_seq_o            (reset_seq)
  );

  assign last  = (mode == FS_MODE_5STEP) ? S5 : S4;
  assign wrap  = (mode == FS_MODE_5STEP) ? W5 : W4;
  assign q_hit = (cnt == S1) | (cnt == S2)
               | (cnt == S3) | (cnt == last);
  assign h_hit = (cnt == S2) | (cnt == last);
  assign mode_o = mode;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt             <= '0;
      mode            <= FS_MODE_4STEP;
      quarter_frame_o <= 1'b0;
      half_frame_o    <= 1'b0;
    end else begin
      quarter_frame_o <= 1'b0;
      half_frame_o    <= 1'b0;
      if (frame_counter_reg_wr_i) begin
        mode <= fs_mode_e'(data_i[7]);
      end
      if (cpu_cycle_en_i) begin
        // delayed restart masks this cycle's compares
        if (reset_seq) begin
          cnt             <= '0;
          quarter_frame_o <= (mode == FS_MODE_5STEP);
          half_frame_o    <= (mode == FS_MODE_5STEP);
        end else begin
          cnt             <= (cnt == wrap) ? '0 : cnt + ONE;
          quarter_frame_o <= q_hit;
          half_frame_o    <= h_hit;
        end
      end
    end
  end

`ifdef APU_FRAME_IRQ_EN
  localparam logic [CNT_W_P-1:0] IRQ_LO = CNT_W_P'(STEP4_P - 1);
  localparam logic [CNT_W_P-1:0] IRQ_HI = CNT_W_P'(STEP4_P + 1);

  logic inhibit;
  logic irq;
  logic irq_set;
  logic irq_clr;
  logic unused_data;

  assign irq_set = cpu_cycle_en_i
                 & ~reset_seq
                 & (mode == FS_MODE_4STEP)
                 & ~inhibit
                 & (cnt >= IRQ_LO)
                 & (cnt <= IRQ_HI);
  assign irq_clr = status_reg_rd_i
                 | (frame_counter_reg_wr_i & data_i[6]);
  assign unused_data = ^data_i[5:0];
  assign frame_irq_o = irq;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inhibit <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (frame_counter_reg_wr_i) begin
        inhibit <= data_i[6];
      end
      if (irq_set) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end
`else
  logic unused_irq;

  assign unused_irq  = ^{data_i[6:0], status_reg_rd_i};
  assign frame_irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_rp2a03_apu_frame_sequencer.sv
// Randomized/directed bench for the APU frame sequencer.
// Instance 0 uses NTSC steps, instance 1 short odd steps.
`timescale 1ns/1ps
module tb_cpu_rp2a03_apu_frame_sequencer;

`ifdef APU_FRAME_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst = '0;
  logic [1:0] cen = '0;
  logic [1:0] wr  = '0;
  logic [1:0] rd  = '0;
  logic [7:0] dat [2];
  logic [1:0] qo, ho, io, mo;

  cpu_rp2a03_apu_frame_sequencer u_dut0 (
    .clk_i                  (clk),
    .rst_i                  (rst[0]),
    .cpu_cycle_en_i         (cen[0]),
    .frame_counter_reg_wr_i (wr[0]),
    .data_i                 (dat[0]),
    .status_reg_rd_i        (rd[0]),
    .mode_o                 (mo[0]),
    .quarter_frame_o        (qo[0]),
    .half_frame_o           (ho[0]),
    .frame_irq_o            (io[0])
  );

  cpu_rp2a03_apu_frame_sequencer #(
    .CNT_W_P (16),
    .STEP1_P (21),
    .STEP2_P (41),
    .STEP3_P (61),
    .STEP4_P (81),
    .STEP5_P (101)
  ) u_dut1 (
    .clk_i                  (clk),
    .rst_i                  (rst[1]),
    .cpu_cycle_en_i         (cen[1]),
    .frame_counter_reg_wr_i (wr[1]),
    .data_i                 (dat[1]),
    .status_reg_rd_i        (rd[1]),
    .mode_o                 (mo[1]),
    .quarter_frame_o        (qo[1]),
    .half_frame_o           (ho[1]),
    .frame_irq_o            (io[1])
  );

  typedef struct {
    int cnt;
    bit mode;
    bit inh;
    bit irq;
    bit pend;
    int ncyc;
    int rst_at;
    bit q;
    bit h;
  } ms_t;

  ms_t m [2];
  int stp [2][5] = '{'{7456, 14912, 22370, 29828, 37280},
                     '{21, 41, 61, 81, 101}};
  int nchk = 0;
  int npass = 0;
  int nfail = 0;
  int qc = 0;
  int hc = 0;
  int ic = 0;

  task automatic finish_up();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got === exp) begin
      npass++;
    end else begin
      nfail++;
      $display("FAIL %s @%0t: got %0d expected %0d",
               tag, $time, got, exp);
      if (nfail >= 40) finish_up();
    end
  endtask

  // cycle-index view: a write at CPU cycle k restarts the
  // sequence at cycle k+3 (even k) or k+4 (odd k)
  task automatic mstep(int d, bit r, bit c, bit w,
                       bit [7:0] x, bit s);
    ms_t st;
    bit  ex;
    bit  set;
    int  top;
    st = m[d];
    if (r) begin
      st = '{default: 0};
      m[d] = st;
      return;
    end
    st.q = 1'b0;
    st.h = 1'b0;
    set  = 1'b0;
    if (c) begin
      ex = st.pend && (st.ncyc == st.rst_at) && !w;
      top = st.mode ? stp[d][4] : stp[d][3];
      if (ex) begin
        st.pend = 1'b0;
        st.cnt  = 0;
        st.q    = st.mode;
        st.h    = st.mode;
      end else begin
        st.q = st.cnt inside {stp[d][0], stp[d][1], stp[d][2], top};
        st.h = (st.cnt == stp[d][1]) || (st.cnt == top);
        set  = !st.mode && !st.inh &&
               (st.cnt >= stp[d][3] - 1) && (st.cnt <= stp[d][3] + 1);
        st.cnt = (st.cnt == top + 1) ? 0 : st.cnt + 1;
      end
      if (w) begin
        st.pend   = 1'b1;
        st.rst_at = st.ncyc + ((st.ncyc % 2 == 1) ? 4 : 3);
      end
      st.ncyc++;
    end
    if (!IRQ_EN) st.irq = 1'b0;
    else if (set) st.irq = 1'b1;
    else if (s || (w && x[6])) st.irq = 1'b0;
    if (w) begin
      st.mode = x[7];
      st.inh  = x[6];
    end
    m[d] = st;
  endtask

  task automatic tick(int d, bit r, bit c, bit w,
                      bit [7:0] x, bit s);
    rst[d] = r;
    cen[d] = c;
    wr[d]  = w;
    dat[d] = x;
    rd[d]  = s;
    @(posedge clk);
    mstep(d, r, c, w, x, s);
    #1;
    chk("quarter", 32'(qo[d]), 32'(m[d].q));
    chk("half", 32'(ho[d]), 32'(m[d].h));
    chk("irq", 32'(io[d]), 32'(m[d].irq));
    chk("mode", 32'(mo[d]), 32'(m[d].mode));
    qc += int'(qo[d]);
    hc += int'(ho[d]);
    ic += int'(io[d]);
    rst[d] = 1'b0;
    cen[d] = 1'b0;
    wr[d]  = 1'b0;
    rd[d]  = 1'b0;
  endtask

  task automatic measure(output int k);
    k = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(1, 0, 1, 0, 8'h00, 0);
      if (qo[1] && k < 0) k = i;
    end
  endtask

  initial begin
    int k;
    bit seen;
    bit r, c, w, s;
    bit [7:0] x;
    dat[0] = '0;
    dat[1] = '0;
    m[0] = '{default: 0};
    m[1] = '{default: 0};

    // NTSC 4-step period
    tick(0, 1, 0, 0, 8'h00, 0);
    tick(0, 1, 0, 0, 8'h00, 0);
    qc = 0; hc = 0;
    for (int i = 0; i < 2000 && m[0].cnt < 1000; i++) begin
      tick(0, 0, 0, 0, 8'h00, 0);
      tick(0, 0, 1, 0, 8'h00, 0);
    end
    for (int i = 0; i < 40000 && m[0].cnt != 29827; i++)
      tick(0, 0, 1, 0, 8'h00, 0);
    tick(0, 0, 1, 0, 8'h00, 0);
    chk("irq_set", 32'(io[0]), 32'(IRQ_EN));
    tick(0, 0, 0, 0, 8'h00, 1);
    chk("irq_rd_clr", 32'(io[0]), 32'd0);
    tick(0, 0, 1, 0, 8'h00, 1);
    chk("irq_rd_race", 32'(io[0]), 32'(IRQ_EN));
    tick(0, 0, 1, 0, 8'h00, 0);
    chk("period_q", qc, 4);
    chk("period_h", hc, 2);
    for (int i = 0; i < 10; i++) tick(0, 0, 1, 0, 8'h00, 0);

    // 5-step period entered with IRQ-clearing write
    qc = 0; hc = 0; ic = 0;
    tick(0, 0, 1, 1, 8'hC0, 0);
    chk("irq_wr_clr", 32'(io[0]), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 45000; i++) begin
      tick(0, 0, 1, 0, 8'h00, 0);
      if (m[0].cnt > 30000) seen = 1'b1;
      if (seen && m[0].cnt == 0) break;
    end
    chk("m5_wrapped", 32'(seen), 32'd1);
    chk("m5_q", qc, 5);
    chk("m5_h", hc, 3);
    chk("m5_irq", ic, 0);

    // write delay: even phase, odd phase, restart at expiry
    tick(1, 1, 0, 0, 8'h00, 0);
    tick(1, 1, 0, 0, 8'h00, 0);
    tick(1, 0, 1, 1, 8'h80, 0);
    measure(k);
    chk("dly_even", k, 3);
    tick(1, 0, 1, 1, 8'h80, 0);
    measure(k);
    chk("dly_odd", k, 4);
    tick(1, 0, 1, 1, 8'h80, 0);
    tick(1, 0, 1, 0, 8'h00, 0);
    tick(1, 0, 1, 0, 8'h00, 0);
    tick(1, 0, 1, 1, 8'h80, 0);
    measure(k);
    chk("dly_restart", k, 4);

    // expiry landing on STEP1 suppresses the quarter
    tick(1, 1, 0, 0, 8'h00, 0);
    tick(1, 0, 1, 1, 8'h00, 0);
    for (int i = 0; i < 60; i++) begin
      if ((m[1].cnt == 18 && m[1].ncyc % 2 == 0) ||
          (m[1].cnt == 17 && m[1].ncyc % 2 == 1)) break;
      tick(1, 0, 1, 0, 8'h00, 0);
    end
    tick(1, 0, 1, 1, 8'h00, 0);
    for (int i = 0; i < 8 && m[1].pend; i++)
      tick(1, 0, 1, 0, 8'h00, 0);
    chk("q_suppr", 32'(qo[1]), 32'd0);

    // reset in the middle of a pending write
    for (int i = 0; i < 60 && m[1].cnt != 14; i++)
      tick(1, 0, 1, 0, 8'h00, 0);
    tick(1, 0, 1, 1, 8'h80, 0);
    tick(1, 0, 1, 0, 8'h00, 0);
    tick(1, 1, 1, 0, 8'h00, 0);
    qc = 0;
    for (int i = 0; i < 6; i++) tick(1, 0, 1, 0, 8'h00, 0);
    chk("rst_drop", qc, 0);

    // random traffic against the model
    for (int i = 0; i < 5000; i++) begin
      r = ($urandom % 2000) == 0;
      c = ($urandom % 4) != 0;
      w = c && (($urandom % 150) == 0);
      x = 8'($urandom);
      s = ($urandom % 40) == 0;
      tick(1, r, c, w, x, s);
    end

    finish_up();
  end

endmodule

// File: doc/cpu_rp2a03_apu_frame_sequencer.md
Name: cpu_RP2A03_apu_frame_sequencer

Overview:
Frame sequencer ($4017 frame counter) of the RP2A03 APU. Counts CPU cycles and emits single-clock quarter-frame and half-frame strobes. Quarter-frame strobes drive the envelope and linear-counter units; half-frame strobes drive the length-counter and sweep units. Raises the frame IRQ in 4-step mode, and sequences $4017 writes with the hardware's parity-dependent reset delay.

Parameters:
CNT_W_P, 16, cycle counter width
STEP1_P, 7456, compare value: quarter
STEP2_P, 14912, compare value: quarter + half
STEP3_P, 22370, compare value: quarter
STEP4_P, 29828, 4-step: quarter + half; IRQ window is STEP4_P-1..STEP4_P+1; wrap at STEP4_P+1
STEP5_P, 37280, 5-step: quarter + half; wrap at STEP5_P+1

Ports:
clk_i  in  1  clock; the only clock
rst_i  in  1  synchronous, active-high reset
cpu_cycle_en_i  in  1  one-clk strobe per CPU cycle; all counting is qualified by it
frame_counter_reg_wr_i  in  1  one-clk $4017 write strobe, coincident with a cpu_cycle_en_i
data_i  in  8  write data; bit7 = mode (1 = 5-step), bit6 = IRQ inhibit
status_reg_rd_i  in  1  one-clk $4015 read strobe; clears the frame IRQ
mode_o  in/out: out  1  current sequencer mode
quarter_frame_o  out  1  one-clk pulse
half_frame_o  out  1  one-clk pulse
frame_irq_o  out  1  frame interrupt flag (level)

Behaviour:
- Reset values: cnt, mode, inhibit, irq, phase, pend, dly = 0. All outputs 0.
- Reset has priority over every other event.
- phase toggles on each cpu_cycle_en_i. phase=1 marks an odd APU half-cycle.
- Counting, on cpu_cycle_en_i:
  - if cnt equals the wrap value for the current mode, cnt <= 0; otherwise cnt <= cnt + 1.
  - All compares use the pre-increment cnt.
- Outputs are registered. quarter_frame_o / half_frame_o go high for exactly one clk, on the edge following a matching cpu_cycle_en_i.
- Compare events:
  - mode 0: quarter at STEP1/2/3/4; half at STEP2/4.
  - mode 1: quarter at STEP1/2/3/5; half at STEP2/5; no IRQ.
- IRQ set: mode 0, inhibit 0, cnt in STEP4_P-1..STEP4_P+1, on cpu_cycle_en_i. The flag holds until cleared.
- IRQ clear: status_reg_rd_i, or a write with bit6 = 1. If set and clear occur in the same clk, set wins.
- $4017 write:
  - mode and inhibit latch immediately.
  - pend <= 1.
  - dly <= 3 if phase = 0, dly <= 4 if phase = 1.
  - dly decrements on each later cpu_cycle_en_i.
- Delay expiry: on the cpu_cycle_en_i where dly reaches 0:
  - cnt <= 0 and pend <= 0.
  - Any compare event in that cycle is suppressed.
  - If mode = 1, quarter and half pulse immediately (next clk).
- A write while pend = 1 restarts the delay; the latest data wins.
- Write and expiry in the same clk: the write wins (delay restarts).
- The counter keeps running during the delay.
- No combinational input-to-output path.
- Max count 37281 fits in CNT_W_P = 16; no overflow possible.

Optional Feature:
APU_FRAME_IRQ_EN
- Defined: IRQ flag logic as specified above.
- Undefined: irq register and clear logic are omitted. frame_irq_o is tied to 0. status_reg_rd_i and bit6 are ignored. Strobes are unchanged.

Decomposition:
- Package cpu_RP2A03_apu_pkg holds:
  - step compare constants (NTSC)
  - mode encoding: FS_MODE_4STEP = 0, FS_MODE_5STEP = 1
  - delay constants: 3 and 4
- One sub-module, cpu_RP2A03_apu_frame_write_delay: phase toggle, dly counter, pend flag. It outputs a one-clk reset_seq pulse.

Test Plan:
- Reset, then run in mode 0 with cpu_cycle_en_i every 2nd clk -> quarter pulses after cnt 7456, 14912, 22370, 29828; half pulses after 14912 and 29828; frame_irq_o = 1 from cnt 29827; cnt wraps to 0 after 29829.
- Write 0x80 -> after the delay, quarter and half pulse immediately; following quarters at 7456, 14912, 22370, 37280; wrap after 37281; frame_irq_o stays 0 over 3 periods.
- IRQ set, then status_reg_rd_i -> cleared next clk. Read coincident with cnt = 29828 -> flag stays 1. Write 0x40 -> cleared, and no set on the next period.
- Write 0x00 at phase 0 -> cnt = 0 exactly 3 cpu cycles later. Write at phase 1 -> 4 cycles later. A second write during the delay restarts the 3/4-cycle count.
- Write expiring at cnt = 7456 -> no quarter pulse; cnt = 0. Reset asserted mid-delay at cnt = 14000 -> all state 0, no pulse, pending write discarded.
- With APU_FRAME_IRQ_EN undefined, full mode-0 period -> frame_irq_o constant 0; quarter/half timing identical to the first scenario.
